// File: rtl/uart_pkg.sv
// Shared UART baud-generation types: oversample ratio encoding, its tick count,
// and the baud FSM state.
package uart_pkg;

    typedef enum logic [1:0] {
        OSR16 = 2'b00,
        OSR13 = 2'b01,
        OSR8  = 2'b10,
        OSR4  = 2'b11
    } osr_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int PHASE_W = 5;

    function automatic logic [PHASE_W-1:0] osr_count(input osr_e osr);
        case (osr)
            OSR16:   return 5'd16;
            OSR13:   return 5'd13;
            OSR8:    return 5'd8;
            default: return 5'd4;
        endcase
    endfunction

endpackage

// File: rtl/baud_frac_acc.sv
// Fractional-divisor accumulator: adds the fraction on every oversample tick and
// reports the carry that stretches the following period by one clock.
module baud_frac_acc #(
    parameter int FRAC_W = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_tick,
    input  logic              i_clear,
    input  logic [FRAC_W-1:0] i_frac,
    output logic              o_carry
);

    logic [FRAC_W-1:0] r_acc;
    logic [FRAC_W:0]   w_sum;

    assign w_sum   = {1'b0, r_acc} + {1'b0, i_frac};
    assign o_carry = w_sum[FRAC_W];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_tick) begin
            r_acc <= w_sum[FRAC_W-1:0];
        end
    end

endmodule

// File: rtl/baud_tick_gen.sv
// Baud tick generator: integer+fractional divisor producing oversample, bit-end and
// mid-bit strobes, with configuration shadowed and applied only on a tick boundary.
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [FRAC_W-1:0] cfg_frac,
    input  logic [1:0]        cfg_osr,
    input  logic              cfg_load,
    output logic              cfg_ack,
    output logic              os_tick,
    output logic              bit_tick,
    output logic              mid_tick,
    output logic [4:0]        os_phase
);

    localparam int CNT_W = DIV_W + 1;

    state_e             r_state;
    state_e             w_state_nx;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nx;
    logic [PHASE_W-1:0] r_phase;
    logic [PHASE_W-1:0] w_phase_nx;

    logic [DIV_W-1:0]   r_div;
    logic [FRAC_W-1:0]  r_frac;
    osr_e               r_osr;
    logic [DIV_W-1:0]   r_sh_div;
    logic [FRAC_W-1:0]  r_sh_frac;
    osr_e               r_sh_osr;
    logic               r_pending;

    logic               r_cfg_ack;
    logic               r_os_tick;
    logic               r_bit_tick;
    logic               r_mid_tick;
    logic               w_bit_nx;
    logic               w_mid_nx;
    logic               w_acc_clr;

    logic               w_carry;
    logic               w_cnt_zero;
    logic               w_tick;
    logic               w_use_port;
    logic               w_idle_apply;
    logic               w_run_apply;
    logic               w_apply;
    logic [DIV_W-1:0]   w_src_div;
    logic [FRAC_W-1:0]  w_src_frac;
    osr_e               w_src_osr;
    logic [DIV_W-1:0]   w_eff_div;
    logic [PHASE_W-1:0] w_osr_n;
    logic               w_last;
    logic               w_mid;
    logic [CNT_W-1:0]   w_period;

    // In IDLE a load takes effect straight from the ports; in RUN it waits in the shadow.
    assign w_use_port   = (r_state == IDLE) && cfg_load;
    assign w_src_div    = w_use_port ? cfg_div             : r_sh_div;
    assign w_src_frac   = w_use_port ? cfg_frac            : r_sh_frac;
    assign w_src_osr    = w_use_port ? osr_e'(cfg_osr)     : r_sh_osr;

    assign w_cnt_zero   = (r_cnt == '0);
    assign w_tick       = (r_state == RUN) && en && w_cnt_zero;
    assign w_idle_apply = (r_state == IDLE) && (cfg_load || r_pending);
    // A load landing on a tick edge is held back so the latest shadow is applied once.
    assign w_run_apply  = w_tick && r_pending && !cfg_load;
    assign w_apply      = w_idle_apply || w_run_apply;
    assign w_eff_div    = w_idle_apply ? w_src_div : r_div;

    assign w_osr_n      = osr_count(r_osr);
    assign w_last       = (r_phase == w_osr_n - PHASE_W'(1));
    assign w_mid        = (r_phase == (w_osr_n >> 1));
    assign w_period     = {1'b0, r_div} + CNT_W'(w_carry);

    baud_frac_acc #(
        .FRAC_W (FRAC_W)
    ) u_frac_acc (
        .clk     (clk),
        .rstn    (rstn),
        .i_tick  (w_tick),
        .i_clear (w_acc_clr),
        .i_frac  (r_frac),
        .o_carry (w_carry)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_state_nx = r_state;
        case (r_state)
            IDLE: if (en && (w_eff_div != '0)) w_state_nx = RUN;
            RUN:  if (!en || (w_run_apply && (r_sh_div == '0))) w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_comb begin
        w_cnt_nx   = '0;
        w_phase_nx = '0;
        w_bit_nx   = 1'b0;
        w_mid_nx   = 1'b0;
        w_acc_clr  = 1'b1;
        if (r_state == IDLE) begin
            if (w_state_nx == RUN) begin
                w_cnt_nx = {1'b0, w_eff_div} - CNT_W'(1);
            end
        end else if (en) begin
            w_acc_clr = 1'b0;
            if (!w_cnt_zero) begin
                w_cnt_nx   = r_cnt - CNT_W'(1);
                w_phase_nx = r_phase;
            end else begin
                // The emitted tick is always judged against the outgoing OSR.
                w_bit_nx = w_last;
                w_mid_nx = w_mid;
                if (w_run_apply) begin
                    w_acc_clr = 1'b1;
                    w_cnt_nx  = (r_sh_div == '0) ? '0 : {1'b0, r_sh_div} - CNT_W'(1);
                end else begin
                    w_cnt_nx   = w_period - CNT_W'(1);
                    w_phase_nx = w_last ? '0 : r_phase + PHASE_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt      <= '0;
            r_phase    <= '0;
            r_os_tick  <= 1'b0;
            r_bit_tick <= 1'b0;
            r_mid_tick <= 1'b0;
            r_cfg_ack  <= 1'b0;
            r_pending  <= 1'b0;
            r_div      <= '0;
            r_frac     <= '0;
            r_osr      <= OSR16;
            // NOTE: the shadow is reset as well so a load discarded by rstn cannot resurface.
            r_sh_div   <= '0;
            r_sh_frac  <= '0;
            r_sh_osr   <= OSR16;
        end else begin
            r_cnt      <= w_cnt_nx;
            r_phase    <= w_phase_nx;
            r_os_tick  <= w_tick;
            r_bit_tick <= w_bit_nx;
            r_mid_tick <= w_mid_nx;
            r_cfg_ack  <= w_apply;
            if (cfg_load) begin
                r_sh_div  <= cfg_div;
                r_sh_frac <= cfg_frac;
                r_sh_osr  <= osr_e'(cfg_osr);
            end
            if (w_apply) begin
                r_pending <= 1'b0;
                r_div     <= w_src_div;
                r_frac    <= w_src_frac;
                r_osr     <= w_src_osr;
            end else if (cfg_load) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign cfg_ack  = r_cfg_ack;
    assign os_tick  = r_os_tick;
    assign bit_tick = r_bit_tick;
    assign mid_tick = r_mid_tick;
    assign os_phase = r_phase;

endmodule
